// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter between the per-core L1 controllers and L2.
// It grants one core at a time in round-robin order and broadcasts the request to the peer snoopers.
// If no peer supplies the line, the request falls back to L2.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | bus free, pick next requester from rr_ptr upward
// S_SNOOP   | broadcast latched addr/type to every non-owner snooper
// S_COLLECT | sample peer snoop responses, decide hit / L2 fallback
// S_L2_REQ  | present request to L2 until l2_ready
// S_L2_WAIT | wait for L2 read data / write acknowledge
// S_DONE    | pulse done to owner with data and shared flag
`timescale 1ns/1ps
module coherence_bus_arbiter #(
    parameter int CPU_CORES   = 4,
    parameter int LINE_ADDR_W = 6,
    parameter int DATA_W      = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [CPU_CORES-1:0]            req_valid,
    input  logic [CPU_CORES*LINE_ADDR_W-1:0] req_addr,
    input  logic [CPU_CORES*2-1:0]          req_type,
    input  logic [CPU_CORES*DATA_W-1:0]     req_wdata,
    output logic [CPU_CORES-1:0]            grant,
    output logic [CPU_CORES-1:0]            done,
    output logic [DATA_W-1:0]               resp_data,
    output logic                            resp_shared,
    output logic [CPU_CORES-1:0]            snoop_valid,
    output logic [LINE_ADDR_W-1:0]          snoop_addr,
    output logic [1:0]                      snoop_req,
    input  logic [CPU_CORES-1:0]            snoop_shared,
    input  logic [CPU_CORES*DATA_W-1:0]     snoop_data,
    output logic                            l2_req_valid,
    output logic                            l2_req_we,
    output logic [LINE_ADDR_W-1:0]          l2_req_addr,
    output logic [DATA_W-1:0]               l2_wdata,
    input  logic                            l2_ready,
    input  logic                            l2_resp_valid,
    input  logic [DATA_W-1:0]               l2_rdata
);
    localparam int OW = (CPU_CORES > 1) ? $clog2(CPU_CORES) : 1;
    localparam logic [1:0] BUS_UPGR = 2'd2;
    localparam logic [1:0] BUS_WB   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_COLLECT, S_L2_REQ, S_L2_WAIT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          rr_ptr_q, owner_q, sel_idx;
    logic                   sel_found;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [1:0]             type_q;
    logic [DATA_W-1:0]      wdata_q, data_q, peer_data;
    logic                   shared_q, supplied;
    logic [CPU_CORES-1:0]   owner_oh, peer_shared;

    assign owner_oh    = {{(CPU_CORES-1){1'b0}}, 1'b1} << owner_q;
    assign peer_shared = snoop_shared & ~owner_oh;
    assign supplied    = |peer_shared;

    // Round-robin pick: scan from rr_ptr upward, the lowest offset wins.
    always_comb begin
        logic [OW-1:0] idx;
        idx       = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = CPU_CORES - 1; i >= 0; i--) begin
            idx = OW'((int'(rr_ptr_q) + i) % CPU_CORES);
            if (req_valid[idx]) begin
                sel_idx   = idx;
                sel_found = 1'b1;
            end
        end
    end

    // Supplying peer data: the lowest-index responding non-owner wins.
    always_comb begin
        peer_data = '0;
        for (int i = CPU_CORES - 1; i >= 0; i--) begin
            if (peer_shared[i]) peer_data = snoop_data[i*DATA_W +: DATA_W];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (sel_found)
                           state_d = (req_type[sel_idx*2 +: 2] == BUS_WB) ? S_L2_REQ : S_SNOOP;
            S_SNOOP:   state_d = S_COLLECT;
            S_COLLECT: state_d = (type_q == BUS_UPGR || supplied) ? S_DONE : S_L2_REQ;
            S_L2_REQ:  if (l2_ready) state_d = S_L2_WAIT;
            S_L2_WAIT: if (l2_resp_valid) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Transaction context, response data and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            type_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            shared_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (sel_found) begin
                    owner_q  <= sel_idx;
                    addr_q   <= req_addr[sel_idx*LINE_ADDR_W +: LINE_ADDR_W];
                    type_q   <= req_type[sel_idx*2 +: 2];
                    wdata_q  <= req_wdata[sel_idx*DATA_W +: DATA_W];
                    data_q   <= '0;
                    shared_q <= 1'b0;
                end
                S_COLLECT: begin
                    shared_q <= supplied;
                    data_q   <= peer_data;
                end
                S_L2_WAIT: if (l2_resp_valid && type_q != BUS_WB) data_q <= l2_rdata;
                S_DONE: rr_ptr_q <= (owner_q == OW'(CPU_CORES - 1)) ? '0 : owner_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state only.
    always_comb begin
        grant        = '0;
        done         = '0;
        resp_data    = '0;
        resp_shared  = 1'b0;
        snoop_valid  = '0;
        snoop_addr   = '0;
        snoop_req    = '0;
        l2_req_valid = 1'b0;
        l2_req_we    = 1'b0;
        l2_req_addr  = '0;
        l2_wdata     = '0;
        if (state_q != S_IDLE) grant = owner_oh;
        case (state_q)
            S_SNOOP: begin
                snoop_valid = ~owner_oh;
                snoop_addr  = addr_q;
                snoop_req   = type_q;
            end
            S_L2_REQ: begin
                l2_req_valid = 1'b1;
                l2_req_we    = (type_q == BUS_WB);
                l2_req_addr  = addr_q;
                l2_wdata     = wdata_q;
            end
            S_DONE: begin
                done        = owner_oh;
                resp_data   = data_q;
                resp_shared = shared_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter with a completion scoreboard and a small L2 responder.
`timescale 1ns/1ps
module tb_coherence_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*2-1:0]  req_type = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    grant, done, snoop_valid;
    logic [DW-1:0]   resp_data, l2_wdata;
    logic            resp_shared, l2_req_valid, l2_req_we;
    logic [AW-1:0]   snoop_addr, l2_req_addr;
    logic [1:0]      snoop_req;
    logic [N-1:0]    snoop_shared = '0;
    logic [N*DW-1:0] snoop_data = '0;
    logic            l2_ready = 1'b0, l2_resp_valid = 1'b0;
    logic [DW-1:0]   l2_rdata = '0;

    always #5 clk = ~clk;

    coherence_bus_arbiter #(.CPU_CORES(N), .LINE_ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .grant(grant), .done(done), .resp_data(resp_data), .resp_shared(resp_shared),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_req(snoop_req),
        .snoop_shared(snoop_shared), .snoop_data(snoop_data),
        .l2_req_valid(l2_req_valid), .l2_req_we(l2_req_we), .l2_req_addr(l2_req_addr),
        .l2_wdata(l2_wdata), .l2_ready(l2_ready), .l2_resp_valid(l2_resp_valid), .l2_rdata(l2_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int   core;
        logic data;
        logic shared;
        logic chk_data;
        int   lat;
    } exp_t;
    exp_t sb[$];

    // Per-transaction observations.
    logic [N-1:0]  sv_acc;
    int            sv_cycles;
    logic [AW-1:0] sv_addr;
    logic [1:0]    sv_req;
    logic          l2_seen, l2_we_c, l2_wd_c;
    logic [AW-1:0] l2_addr_c;

    // L2 responder: l2_ready after l2_rdy_dly cycles of request, response l2_resp_dly cycles later.
    int l2_rdy_dly = 2, l2_resp_dly = 2, l2_ph = 0, l2_cnt = 0;
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l2_ready = 1'b0; l2_resp_valid = 1'b0; l2_ph = 0; l2_cnt = 0;
        end else begin
            case (l2_ph)
                0: begin
                    l2_resp_valid = 1'b0;
                    if (l2_req_valid) begin
                        if (l2_cnt >= l2_rdy_dly) begin l2_ready = 1'b1; l2_ph = 1; l2_cnt = 0; end
                        else l2_cnt++;
                    end
                end
                1: begin
                    l2_ready = 1'b0;
                    if (l2_cnt >= l2_resp_dly) begin l2_resp_valid = 1'b1; l2_ph = 2; l2_cnt = 0; end
                    else l2_cnt++;
                end
                default: begin l2_resp_valid = 1'b0; l2_ph = 0; end
            endcase
        end
    end

    // Bus invariants every cycle: grant/done one-hot or zero, owner never snooped.
    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            assert (($onehot0(grant) && $onehot0(done) && ((snoop_valid & grant) == '0)) === 1'b1)
            else begin
                bad++;
                $error("FAIL bus_invariant observed grant=%b done=%b snoop_valid=%b expected one-hot0, owner unsnooped",
                       grant, done, snoop_valid);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int core, input logic [1:0] t, input logic [AW-1:0] a, input logic wd);
        req_valid[core] = 1'b1;
        req_addr[core*AW +: AW] = a;
        req_type[core*2 +: 2] = t;
        req_wdata[core*DW +: DW] = wd;
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, grant, done, resp_data, resp_shared, snoop_valid, snoop_addr, snoop_req,
                l2_req_valid, l2_req_we, l2_req_addr, l2_wdata};
    endfunction

    // Wait for a done pulse, record bus activity, then pop and compare against the scoreboard.
    task automatic run_txn(input string tag, input int max);
        exp_t e;
        int n;
        logic got;
        logic [N-1:0] dn;
        logic rd, rs;
        sv_acc = '0; sv_cycles = 0; sv_addr = '0; sv_req = '0;
        l2_seen = 1'b0; l2_we_c = 1'b0; l2_wd_c = 1'b0; l2_addr_c = '0;
        n = 0; got = 1'b0; dn = '0; rd = 1'b0; rs = 1'b0;
        while (!got && n < max) begin
            @(negedge clk);
            if (snoop_valid != '0) begin
                sv_acc |= snoop_valid; sv_cycles++; sv_addr = snoop_addr; sv_req = snoop_req;
            end
            if (l2_req_valid && !l2_seen) begin
                l2_seen = 1'b1; l2_we_c = l2_req_we; l2_wd_c = l2_wdata[0]; l2_addr_c = l2_req_addr;
            end
            if (done != '0) begin got = 1'b1; dn = done; rd = resp_data[0]; rs = resp_shared; end
            else n++;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            if (got) begin
                chk({tag, "_done_owner"}, 32'(dn), 32'(1) << e.core);
                chk({tag, "_latency"}, 32'(n), 32'(e.lat));
                chk({tag, "_resp_shared"}, 32'(rs), 32'(e.shared));
                if (e.chk_data) chk({tag, "_resp_data"}, 32'(rd), 32'(e.data));
            end
        end
    endtask

    task automatic push(input int core, input logic d, input logic s, input logic cd, input int lat);
        exp_t e;
        e.core = core; e.data = d; e.shared = s; e.chk_data = cd; e.lat = lat;
        sb.push_back(e);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;

        // Peer hit: core 1 RD, core 3 supplies data 1.
        @(posedge clk); #1;
        snoop_shared = 4'b1000; snoop_data = 4'b1000;
        set_req(1, 2'd0, 6'h2A, 1'b0);
        push(1, 1'b1, 1'b1, 1'b1, 3);
        run_txn("t1_rd_hit", 40);
        req_valid = '0;
        chk("t1_snoop_valid", 32'(sv_acc), 32'b1101);
        chk("t1_snoop_cycles", 32'(sv_cycles), 32'd1);
        chk("t1_snoop_addr", 32'(sv_addr), 32'h2A);
        chk("t1_snoop_req", 32'(sv_req), 32'd0);
        chk("t1_no_l2", 32'(l2_seen), 32'd0);

        // L2 read: core 0 RDX, no peer. IDLE,SNOOP,COLLECT, 3 cycles L2_REQ, 3 cycles L2_WAIT -> done at 9.
        @(posedge clk); #1;
        snoop_shared = '0; snoop_data = '0; l2_rdata = 1'b1; l2_rdy_dly = 2; l2_resp_dly = 2;
        set_req(0, 2'd1, 6'h05, 1'b0);
        push(0, 1'b1, 1'b0, 1'b1, 9);
        run_txn("t2_rdx_l2", 40);
        req_valid = '0;
        chk("t2_snoop_valid", 32'(sv_acc), 32'b1110);
        chk("t2_l2_seen", 32'(l2_seen), 32'd1);
        chk("t2_l2_we", 32'(l2_we_c), 32'd0);
        chk("t2_l2_addr", 32'(l2_addr_c), 32'h05);

        // Writeback: core 2 WB skips snooping. IDLE, 3 cycles L2_REQ, 3 cycles L2_WAIT -> done at 7.
        @(posedge clk); #1;
        snoop_shared = 4'b1111; snoop_data = 4'b1111;
        set_req(2, 2'd3, 6'h11, 1'b1);
        push(2, 1'b0, 1'b0, 1'b0, 7);
        run_txn("t3_wb", 40);
        req_valid = '0;
        chk("t3_no_snoop", 32'(sv_cycles), 32'd0);
        chk("t3_l2_we", 32'(l2_we_c), 32'd1);
        chk("t3_l2_wdata", 32'(l2_wd_c), 32'd1);
        chk("t3_l2_addr", 32'(l2_addr_c), 32'h11);

        // Reset so rr_ptr restarts at 0, then all cores UPGR continuously: 0,1,2,3,0.
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        snoop_shared = '0; snoop_data = '0;
        for (int c = 0; c < N; c++) set_req(c, 2'd2, 6'(8 + c), 1'b0);
        push(0, 1'b0, 1'b0, 1'b0, 3);
        push(1, 1'b0, 1'b0, 1'b0, 3);
        push(2, 1'b0, 1'b0, 1'b0, 3);
        push(3, 1'b0, 1'b0, 1'b0, 3);
        push(0, 1'b0, 1'b0, 1'b0, 3);
        run_txn("t4_upgr_a", 40);
        run_txn("t4_upgr_b", 40);
        run_txn("t4_upgr_c", 40);
        run_txn("t4_upgr_d", 40);
        run_txn("t4_upgr_e", 40);
        req_valid = '0;

        // Multiple suppliers: cores 0 and 3 respond, core 0 data wins; owner's own bit set too.
        @(posedge clk); #1;
        snoop_shared = 4'b1101; snoop_data = 4'b0001;
        set_req(2, 2'd0, 6'h22, 1'b0);
        push(2, 1'b1, 1'b1, 1'b1, 3);
        run_txn("t5_multi", 40);
        req_valid = '0;
        chk("t5_snoop_valid", 32'(sv_acc), 32'b1011);
        chk("t5_no_l2", 32'(l2_seen), 32'd0);

        // Only the owner claims shared: must be ignored, falls back to L2.
        @(posedge clk); #1;
        snoop_shared = 4'b0100; snoop_data = 4'b0100; l2_rdata = 1'b0;
        set_req(2, 2'd0, 6'h23, 1'b0);
        push(2, 1'b0, 1'b0, 1'b1, 9);
        run_txn("t5b_owner_only", 40);
        req_valid = '0;
        chk("t5b_l2_seen", 32'(l2_seen), 32'd1);

        // Reset during L2_WAIT: core 3 RD with slow L2; rr_ptr is 3 beforehand.
        @(posedge clk); #1;
        snoop_shared = '0; snoop_data = '0; l2_rdy_dly = 0; l2_resp_dly = 30; l2_rdata = 1'b1;
        set_req(3, 2'd0, 6'h3F, 1'b0);
        repeat (6) @(negedge clk);
        chk("t6_in_l2_wait", {27'd0, grant, l2_req_valid}, {27'd0, 4'b1000, 1'b0});
        #2 reset_n = 1'b0;
        set_req(1, 2'd0, 6'h07, 1'b0);
        #1 chk("t6_async_reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        chk("t6_no_done_in_reset", 32'(done), 32'd0);
        l2_rdy_dly = 2; l2_resp_dly = 2;
        @(posedge clk); #2 reset_n = 1'b1;
        push(1, 1'b1, 1'b0, 1'b1, 9);
        run_txn("t6_regrant", 40);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- Owns the shared snooping bus between the per-core L1 cache controllers and L2.
- Grants one core's bus request at a time using round-robin arbitration.
- Broadcasts the granted request to every other core's snooper and collects the snoop responses.
- If no peer supplies data, it falls back to an L2 read or write, then returns data and a shared flag to the requester.

Parameters:
- CPU_CORES, 4, number of requesting cores / snoopers
- LINE_ADDR_W, 6, line address width (ADDR_BITS - OFFSET_BITS)
- DATA_W, 1, cacheline data width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  CPU_CORES  per-core bus request; held high, fields stable, until matching done pulse
- req_addr  in  CPU_CORES*LINE_ADDR_W  per-core line address, core i at slice i
- req_type  in  CPU_CORES*2  per-core bus_req_t (BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3)
- req_wdata  in  CPU_CORES*DATA_W  writeback data, BUS_WB only
- grant  out  CPU_CORES  one-hot current bus owner, high from SNOOP through DONE
- done  out  CPU_CORES  one-cycle completion pulse to the owner
- resp_data  out  DATA_W  line data, valid with done (RD/RDX)
- resp_shared  out  1  any peer asserted snoop_shared, valid with done
- snoop_valid  out  CPU_CORES  per-snooper valid; owner's bit always 0
- snoop_addr  out  LINE_ADDR_W  broadcast address
- snoop_req  out  2  broadcast bus_req_t
- snoop_shared  in  CPU_CORES  per-snooper response, asserted the cycle after snoop_valid
- snoop_data  in  CPU_CORES*DATA_W  per-snooper data, valid with snoop_shared
- l2_req_valid  out  1  L2 request
- l2_req_we  out  1  1 = write (BUS_WB), 0 = read
- l2_req_addr  out  LINE_ADDR_W  L2 address
- l2_wdata  out  DATA_W  L2 write data
- l2_ready  in  1  L2 accepts the request when high with l2_req_valid
- l2_resp_valid  in  1  read data valid / write acknowledge
- l2_rdata  in  DATA_W  L2 read data

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, all outputs 0, latched owner/addr/type/data cleared. Reset mid-transaction aborts it with no done pulse.
- FSM states: IDLE, SNOOP, COLLECT, L2_REQ, L2_WAIT, DONE.
- IDLE: if any req_valid, select the first requesting core scanning from rr_ptr upward (wrap mod CPU_CORES). Latch owner, addr, type, wdata. Go to SNOOP; BUS_WB goes directly to L2_REQ.
- SNOOP (1 cycle): snoop_valid = all ones except owner bit; snoop_addr/snoop_req = latched values. Go to COLLECT.
- COLLECT (1 cycle): sample snoop_shared/snoop_data, masking the owner bit.
  - supplied = OR of the masked bits.
  - data = snoop_data of the lowest-index asserting core.
  - BUS_UPGR -> DONE.
  - RD/RDX with supplied -> DONE, using the snoop data.
  - Otherwise -> L2_REQ.
- L2_REQ: l2_req_valid=1, we=(type==BUS_WB), addr/wdata latched. Leave to L2_WAIT on the cycle l2_ready=1.
- L2_WAIT: on l2_resp_valid, latch l2_rdata (reads only) -> DONE.
- DONE (1 cycle):
  - done[owner]=1.
  - resp_data = latched data.
  - resp_shared = supplied (always 0 for BUS_WB).
  - rr_ptr = owner+1 mod CPU_CORES.
  - Go to IDLE.
- Latency from req_valid seen in IDLE:
  - peer hit: done at IDLE+3 cycles.
  - UPGR: done at +3.
  - L2 path: +3 + L2 handshake cycles.
- Requests from non-owners are ignored until IDLE; no new grant while busy. Requests arriving during DONE are evaluated in the following IDLE.
- Owner dropping req_valid mid-transaction is illegal; the transaction completes regardless.
- l2_resp_valid outside L2_WAIT and snoop_shared outside COLLECT are ignored.
- grant is one-hot or zero at all times; at most one done bit per cycle.

Test Plan:
- Core 1 BUS_RD addr 0x2A; core 3 responds snoop_shared=1, data=1 in COLLECT -> snoop_valid=4'b1101 for one cycle; done[1] at +3 cycles; resp_data=1, resp_shared=1; no l2_req_valid.
- Core 0 BUS_RDX addr 0x05, no snooper responds; L2 ready after 2 cycles, rdata=1 two cycles later -> l2_req_valid with we=0, addr 0x05; done[0] with resp_data=1, resp_shared=0.
- Core 2 BUS_WB addr 0x11, wdata=1 -> no snoop_valid; l2_req_valid, we=1, l2_wdata=1; done[2] after l2_resp_valid; resp_shared=0.
- All four req_valid held continuously, each BUS_UPGR -> grants in order 0,1,2,3,0; each done at 3-cycle spacing plus 1 IDLE cycle; never two grant bits set.
- Core 2 BUS_RD; cores 0 and 3 both assert snoop_shared, data 1 and 0 -> resp_data=1 (core 0 priority); owner's own snoop_shared bit forced high is ignored.
- reset_n deasserted during L2_WAIT -> all outputs 0 asynchronously, no done; after release, a held core-1 request is regranted with rr_ptr=0.
